// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver that synchronises bclk/lrclk/sdata into clk and emits stereo sample pairs.
// Defining I2S_RX_MONO_MIX_EN adds mono_out = (left + right) >>> 1.
module i2s_rx #(
    parameter int SAMPLE_W    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i2s_bclk,
    input  logic                       i2s_lrclk,
    input  logic                       i2s_sdata,
    output logic signed [SAMPLE_W-1:0] left_out,
    output logic signed [SAMPLE_W-1:0] right_out,
`ifdef I2S_RX_MONO_MIX_EN
    output logic signed [SAMPLE_W-1:0] mono_out,
`endif
    output logic                       sample_valid,
    output logic                       frame_err
);
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
    state_t state, state_next;
    logic [SYNC_STAGES-1:0] bclk_sync, lr_sync, sd_sync;
    logic bclk_q, lr_q, left_ok;
    logic [6:0] cnt;
    logic [SAMPLE_W-1:0] shreg, hold, word;
    logic rise, boundary, done, short_err;
    logic bclk_s, lr_s, sd_s;
    assign bclk_s = bclk_sync[SYNC_STAGES-1];
    assign lr_s   = lr_sync[SYNC_STAGES-1];
    assign sd_s   = sd_sync[SYNC_STAGES-1];
`ifdef I2S_RX_MONO_MIX_EN
    logic signed [SAMPLE_W:0] mix_sum;
    assign mix_sum = $signed({hold[SAMPLE_W-1], hold}) + $signed({word[SAMPLE_W-1], word});
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    always_comb begin
        state_next = state;
        rise       = bclk_s & ~bclk_q;
        boundary   = rise && (lr_s != lr_q);
        done       = rise && !boundary && state != IDLE && cnt == 7'(SAMPLE_W - 1);
        short_err  = boundary && state != IDLE && cnt < 7'(SAMPLE_W);
        word       = {shreg[SAMPLE_W-2:0], sd_s};
        if (boundary)
            state_next = (state == IDLE) ? (lr_s ? IDLE : LEFT) : (lr_s ? RIGHT : LEFT);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync    <= '0;
            lr_sync      <= '0;
            sd_sync      <= '0;
            bclk_q       <= 1'b0;
            lr_q         <= 1'b0;
            left_ok      <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            hold         <= '0;
            left_out     <= '0;
            right_out    <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
            mono_out     <= '0;
`endif
        end else begin
            bclk_sync    <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lr_sync      <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
            sd_sync      <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_q       <= bclk_s;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
            if (rise) lr_q <= lr_s;
            if (boundary) begin
                // boundary bit is the previous word's LSB slot delay, so it is not shifted in
                cnt <= '0;
                if (short_err) begin
                    frame_err <= 1'b1;
                    left_ok   <= 1'b0;
                end
            end else if (rise && state != IDLE) begin
                if (cnt != 7'd127) cnt <= cnt + 7'd1;
                if (cnt < 7'(SAMPLE_W)) shreg <= word;
                if (done && state == LEFT) begin
                    hold    <= word;
                    left_ok <= 1'b1;
                end
                if (done && state == RIGHT) begin
                    if (left_ok) begin
                        left_out     <= hold;
                        right_out    <= word;
                        sample_valid <= 1'b1;
                        left_ok      <= 1'b0;
`ifdef I2S_RX_MONO_MIX_EN
                        mono_out     <= SAMPLE_W'(mix_sum >>> 1);
`endif
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
